// File: rtl/image_rank_buffer.sv
// Sorted collection buffer for per-image ranking records.
// Records are kept ordered by {colour, avg} on arrival; a full set is streamed out in order.
module image_rank_buffer #(
    parameter int NUM_IMG = 32,
    parameter int AVG_W   = 8,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rec_valid,
    input  logic [1:0]       rec_color,
    input  logic [AVG_W-1:0] rec_avg,
    input  logic [IDX_W-1:0] rec_index,
    output logic             busy,
    output logic             out_valid,
    output logic [1:0]       color_index,
    output logic [IDX_W-1:0] image_out_index
);
    localparam int KEY_W = 2 + AVG_W;
    localparam int CNT_W = $clog2(NUM_IMG + 1);
    localparam int PTR_W = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1;

    typedef enum logic {S_FILL, S_DRAIN} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [1:0]       r_color [NUM_IMG];
    logic [AVG_W-1:0] r_avg   [NUM_IMG];
    logic [IDX_W-1:0] r_idx   [NUM_IMG];
    logic             r_out_valid;
    logic [1:0]       r_out_color;
    logic [IDX_W-1:0] r_out_idx;

    logic [KEY_W-1:0]   w_new_key;
    logic [NUM_IMG-1:0] w_gt;
    logic [NUM_IMG-1:0] w_ins;
    logic [NUM_IMG-1:0] w_shift;
    logic [1:0]         w_nxt_color [NUM_IMG];
    logic [AVG_W-1:0]   w_nxt_avg   [NUM_IMG];
    logic [IDX_W-1:0]   w_nxt_idx   [NUM_IMG];
    logic               w_accept;

    assign busy            = (r_state == S_DRAIN) | r_out_valid;
    assign out_valid       = r_out_valid;
    assign color_index     = r_out_color;
    assign image_out_index = r_out_idx;
    assign w_accept        = rec_valid & ~busy;
    assign w_new_key       = {rec_color, rec_avg};

    // Stored entries strictly greater than the new key form a suffix of the
    // occupied region; they move up one slot and the new record lands just
    // below them, which keeps equal keys in arrival order.
    for (genvar j = 0; j < NUM_IMG; j++) begin : g_slot
        assign w_gt[j] = (CNT_W'(j) < r_count) && ({r_color[j], r_avg[j]} > w_new_key);
        if (j == 0) begin : g_head
            assign w_shift[j]     = 1'b0;
            assign w_ins[j]       = w_gt[j] || (r_count == '0);
            assign w_nxt_color[j] = w_ins[j] ? rec_color : r_color[j];
            assign w_nxt_avg[j]   = w_ins[j] ? rec_avg   : r_avg[j];
            assign w_nxt_idx[j]   = w_ins[j] ? rec_index : r_idx[j];
        end else begin : g_body
            assign w_shift[j]     = w_gt[j-1];
            assign w_ins[j]       = !w_gt[j-1] && (w_gt[j] || (r_count == CNT_W'(j)));
            assign w_nxt_color[j] = w_shift[j] ? r_color[j-1] : (w_ins[j] ? rec_color : r_color[j]);
            assign w_nxt_avg[j]   = w_shift[j] ? r_avg[j-1]   : (w_ins[j] ? rec_avg   : r_avg[j]);
            assign w_nxt_idx[j]   = w_shift[j] ? r_idx[j-1]   : (w_ins[j] ? rec_index : r_idx[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FILL;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_color <= '0;
            r_out_idx   <= '0;
            for (int i = 0; i < NUM_IMG; i++) begin
                r_color[i] <= '0;
                r_avg[i]   <= '0;
                r_idx[i]   <= '0;
            end
        end else begin
            case (r_state)
                S_FILL: begin
                    r_out_valid <= 1'b0;
                    r_out_color <= '0;
                    r_out_idx   <= '0;
                    if (w_accept) begin
                        for (int i = 0; i < NUM_IMG; i++) begin
                            r_color[i] <= w_nxt_color[i];
                            r_avg[i]   <= w_nxt_avg[i];
                            r_idx[i]   <= w_nxt_idx[i];
                        end
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == CNT_W'(NUM_IMG - 1))
                            r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_out_valid <= 1'b1;
                    r_out_color <= r_color[r_rd_ptr];
                    r_out_idx   <= r_idx[r_rd_ptr];
                    if (r_rd_ptr == PTR_W'(NUM_IMG - 1)) begin
                        r_state  <= S_FILL;
                        r_count  <= '0;
                        r_rd_ptr <= '0;
                    end else begin
                        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_image_rank_buffer.sv
// Directed bench for image_rank_buffer: cycle model predicts acceptance/busy,
// completed frames are stably sorted into a queue and popped on out_valid.
module tb_image_rank_buffer;
    localparam int NUM_IMG = 32;
    localparam int AVG_W   = 8;
    localparam int IDX_W   = 5;

    typedef struct packed {
        logic [1:0]       color;
        logic [AVG_W-1:0] avg;
        logic [IDX_W-1:0] idx;
    } rec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             rec_valid;
    logic [1:0]       rec_color;
    logic [AVG_W-1:0] rec_avg;
    logic [IDX_W-1:0] rec_index;
    logic             busy;
    logic             out_valid;
    logic [1:0]       color_index;
    logic [IDX_W-1:0] image_out_index;

    int   checks = 0;
    int   errors = 0;
    rec_t frame_q[$];
    rec_t exp_q[$];
    int   m_drain = 0;
    logic m_ov = 1'b0;

    always #5 clk = ~clk;

    image_rank_buffer #(.NUM_IMG(NUM_IMG), .AVG_W(AVG_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .rec_valid(rec_valid), .rec_color(rec_color),
        .rec_avg(rec_avg), .rec_index(rec_index), .busy(busy), .out_valid(out_valid),
        .color_index(color_index), .image_out_index(image_out_index)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stable ordering by enumerating keys ascending and scanning in arrival order.
    task automatic load_frame();
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < (1 << AVG_W); a++)
                foreach (frame_q[i])
                    if (frame_q[i].color == 2'(c) && frame_q[i].avg == AVG_W'(a))
                        exp_q.push_back(frame_q[i]);
        frame_q.delete();
        m_drain = NUM_IMG;
    endtask

    task automatic cycle(input logic rst, input logic rv, input logic [1:0] c,
                         input logic [AVG_W-1:0] a, input logic [IDX_W-1:0] ix);
        logic busy_pre;
        rec_t r;
        reset = rst; rec_valid = rv; rec_color = c; rec_avg = a; rec_index = ix;
        if (rst) begin
            frame_q.delete();
            exp_q.delete();
            m_drain = 0;
            m_ov = 1'b0;
        end else begin
            busy_pre = (m_drain > 0) || m_ov;
            if (m_drain > 0) begin
                m_ov = 1'b1;
                m_drain--;
            end else begin
                m_ov = 1'b0;
            end
            if (rv && !busy_pre) begin
                r.color = c; r.avg = a; r.idx = ix;
                frame_q.push_back(r);
                if (frame_q.size() == NUM_IMG) load_frame();
            end
        end
        @(posedge clk); #1;
        chk("busy", {31'd0, busy}, {31'd0, (m_drain > 0) || m_ov});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        if (out_valid === 1'b1 && exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("color_index", 32'(color_index), 32'(r.color));
            chk("image_out_index", 32'(image_out_index), 32'(r.idx));
        end else if (out_valid !== 1'b1) begin
            chk("idle_color_index", 32'(color_index), 32'd0);
            chk("idle_image_out_index", 32'(image_out_index), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 2'd0, '0, '0);
    endtask

    initial begin
        // T1: reset with a record presented; it must not be counted
        repeat (3) cycle(1'b1, 1'b1, 2'd2, 8'h55, 5'd7);

        // T2: mixed colours, descending avg
        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 2'(i % 3), 8'(255 - i), 5'(i));
        idle(35);

        // T3: identical keys keep arrival order
        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 2'd1, 8'h40, 5'(i));
        idle(35);

        // T4: key extremes with one undefined colour in the middle
        for (int i = 0; i < 32; i++) begin
            if (i == 10) cycle(1'b0, 1'b1, 2'd3, 8'h00, 5'(i));
            else         cycle(1'b0, 1'b1, 2'd0, (i % 2) ? 8'h00 : 8'hFF, 5'(i));
        end
        idle(35);

        // T5: continuous rec_valid across busy
        for (int i = 0; i < 100; i++)
            cycle(1'b0, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 5'(i));
        idle(35);

        // T6: reset during the 10th output cycle, then a clean frame
        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 2'((i * 7) % 4), 8'(i * 37), 5'(31 - i));
        idle(10);
        cycle(1'b1, 1'b0, 2'd0, '0, '0);
        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 2'((i * 5) % 4), 8'(i * 11), 5'(i));
        idle(35);

        chk("all_outputs_seen", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
